// File: rtl/burst_data_pipe.sv
// burst_data_pipe: request pipeline between a host traffic source and the
// DDR4 command/data pins.
//   - Host requests (req_*) are queued in a pending FIFO (req_ready = not full).
//   - act_rdy moves the pending head into a CAS FIFO and an RW FIFO and
//     issues ACT; cas_rdy pops the CAS FIFO and issues CAS_R/CAS_W.
//   - rw_rdy pops the RW FIFO and starts either a write burst (preamble then
//     BL8/BC4 beats on dq_out/dqs_out) or a one-cycle dimm_rd pulse for reads.
//   - cmd_*: registered command bus; pend/cas/rw_level: FIFO occupancy;
//     err: sticky strobe-misuse flags.

// Small circular FIFO. dout shows the head entry; the caller must not pop
// when empty or push when full without a simultaneous pop.
module burst_data_pipe_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock_t,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;

    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;

    // Storage array: written at the write pointer, no reset needed for data.
    always_ff @(posedge clock_t) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            if (pop)  rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            case ({push, pop})
                2'b10:   level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end
endmodule

module burst_data_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int TA_WIDTH   = 29,
    parameter int ADDR_LSB   = 3,
    parameter int DQ_WIDTH   = 8,
    parameter int DEPTH      = 8
) (
    input  logic                      clock_t,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_rw,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [8*DQ_WIDTH-1:0]     req_wdata,
    input  logic                      act_rdy,
    input  logic                      cas_rdy,
    input  logic                      rw_rdy,
    input  logic                      bc4,
    input  logic                      wpre2,
    output logic                      cmd_valid,
    output logic [1:0]                cmd_code,
    output logic [TA_WIDTH-1:0]       cmd_addr,
    output logic [DQ_WIDTH-1:0]       dq_out,
    output logic                      dq_oe,
    output logic                      dqs_oe,
    output logic                      dqs_out,
    output logic                      dimm_rd,
    output logic [$clog2(DEPTH):0]    pend_level,
    output logic [$clog2(DEPTH):0]    cas_level,
    output logic [$clog2(DEPTH):0]    rw_level,
    output logic [2:0]                err
);
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int WD_W   = 8 * DQ_WIDTH;
    localparam int PEND_W = 2 + TA_WIDTH + WD_W;
    localparam int CASF_W = 2 + TA_WIDTH;
    localparam int RWF_W  = 2 + WD_W;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ZERO_LVL = {LVL_W{1'b0}};
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;
    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_ACT  = 2'd1;
    localparam logic [1:0] CMD_CASR = 2'd2;
    localparam logic [1:0] CMD_CASW = 2'd3;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PRE = 2'd1, ST_DATA = 2'd2} state_t;

    // Physical-to-memory address mapping: drop the ADDR_LSB low bits.
    function automatic logic [TA_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_LSB +: TA_WIDTH];
    endfunction

    logic                  unused_addr_s;
    logic                  push_pend_s, act_try_s, act_ok_s, act_go_s, act_fail_s;
    logic                  cas_go_s, cas_err_s, rw_go_s, rw_err_s;
    logic [PEND_W-1:0]     pend_dout_s;
    logic [CASF_W-1:0]     cas_dout_s;
    logic [RWF_W-1:0]      rwf_dout_s;
    logic [1:0]            pend_rw_s, cas_rw_s, rwf_rw_s;
    logic [TA_WIDTH-1:0]   pend_addr_s, cas_addr_s;
    logic [WD_W-1:0]       pend_wdata_s, rwf_wdata_s;

    logic                  act_pend_r;
    logic                  cmd_valid_r;
    logic [1:0]            cmd_code_r;
    logic [TA_WIDTH-1:0]   cmd_addr_r;
    logic [2:0]            err_r;
    state_t                state_r;
    logic [1:0]            pre_cnt_r;
    logic [3:0]            bl_r;
    logic [3:0]            beat_r;
    logic [WD_W-1:0]       shreg_r;
    logic [DQ_WIDTH-1:0]   dq_out_r;
    logic                  dq_oe_r, dqs_oe_r, dqs_out_r, dimm_rd_r;

    // Address bits outside the mapped window are intentionally ignored.
    assign unused_addr_s = ^req_addr;

    assign {pend_rw_s, pend_addr_s, pend_wdata_s} = pend_dout_s;
    assign {cas_rw_s, cas_addr_s}                 = cas_dout_s;
    assign {rwf_rw_s, rwf_wdata_s}                = rwf_dout_s;

    assign req_ready   = (pend_level < FULL_LVL);
    assign push_pend_s = req_valid & req_ready;

    // CAS owns the command bus: any ACT attempt waits out a cas_rdy cycle.
    assign act_try_s  = (act_rdy | act_pend_r) & ~cas_rdy;
    assign act_ok_s   = (pend_level != ZERO_LVL) & (cas_level < FULL_LVL) & (rw_level < FULL_LVL);
    assign act_go_s   = act_try_s & act_ok_s;
    assign act_fail_s = act_try_s & ~act_ok_s;
    assign cas_go_s   = cas_rdy & (cas_level != ZERO_LVL);
    assign cas_err_s  = cas_rdy & (cas_level == ZERO_LVL);
    assign rw_go_s    = rw_rdy & (state_r == ST_IDLE) & (rw_level != ZERO_LVL);
    assign rw_err_s   = rw_rdy & ~rw_go_s;

    burst_data_pipe_fifo #(.WIDTH(PEND_W), .DEPTH(DEPTH)) u_pend (
        .clock_t(clock_t), .reset_n(reset_n), .push(push_pend_s), .pop(act_go_s),
        .din({req_rw, map_addr(req_addr), req_wdata}), .dout(pend_dout_s), .level(pend_level)
    );
    burst_data_pipe_fifo #(.WIDTH(CASF_W), .DEPTH(DEPTH)) u_cas (
        .clock_t(clock_t), .reset_n(reset_n), .push(act_go_s), .pop(cas_go_s),
        .din({pend_rw_s, pend_addr_s}), .dout(cas_dout_s), .level(cas_level)
    );
    burst_data_pipe_fifo #(.WIDTH(RWF_W), .DEPTH(DEPTH)) u_rw (
        .clock_t(clock_t), .reset_n(reset_n), .push(act_go_s), .pop(rw_go_s),
        .din({pend_rw_s, pend_wdata_s}), .dout(rwf_dout_s), .level(rw_level)
    );

    // Deferred ACT flag, command bus register and sticky error flags.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            act_pend_r  <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= CMD_NOP;
            cmd_addr_r  <= {TA_WIDTH{1'b0}};
            err_r       <= 3'b000;
        end else begin
            if (act_rdy & cas_rdy) begin
                act_pend_r <= 1'b1;
            end else if (act_try_s) begin
                act_pend_r <= 1'b0;
            end else begin
                act_pend_r <= act_pend_r;
            end

            if (cas_go_s && (cas_rw_s == RW_READ || cas_rw_s == RW_WRITE)) begin
                cmd_valid_r <= 1'b1;
                cmd_code_r  <= (cas_rw_s == RW_READ) ? CMD_CASR : CMD_CASW;
                cmd_addr_r  <= cas_addr_s;
            end else if (act_go_s) begin
                cmd_valid_r <= 1'b1;
                cmd_code_r  <= CMD_ACT;
                cmd_addr_r  <= pend_addr_s;
            end else begin
                cmd_valid_r <= 1'b0;
                cmd_code_r  <= CMD_NOP;
                cmd_addr_r  <= {TA_WIDTH{1'b0}};
            end

            err_r <= err_r | {rw_err_s, cas_err_s, act_fail_s};
        end
    end

    // Data-phase FSM: preamble then one beat per cycle, LSB beat first.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            pre_cnt_r <= 2'd0;
            bl_r      <= 4'd0;
            beat_r    <= 4'd0;
            shreg_r   <= {WD_W{1'b0}};
            dq_out_r  <= {DQ_WIDTH{1'b0}};
            dq_oe_r   <= 1'b0;
            dqs_oe_r  <= 1'b0;
            dqs_out_r <= 1'b0;
            dimm_rd_r <= 1'b0;
        end else begin
            dimm_rd_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    dq_out_r  <= {DQ_WIDTH{1'b0}};
                    dq_oe_r   <= 1'b0;
                    dqs_oe_r  <= 1'b0;
                    dqs_out_r <= 1'b0;
                    if (rw_go_s && rwf_rw_s == RW_WRITE) begin
                        state_r   <= ST_PRE;
                        // Holds remaining preamble cycles minus one.
                        pre_cnt_r <= wpre2 ? 2'd1 : 2'd0;
                        bl_r      <= bc4 ? 4'd4 : 4'd8;
                        shreg_r   <= rwf_wdata_s;
                        dqs_oe_r  <= 1'b1;
                    end else if (rw_go_s && rwf_rw_s == RW_READ) begin
                        dimm_rd_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PRE: begin
                    if (pre_cnt_r == 2'd0) begin
                        state_r   <= ST_DATA;
                        dq_out_r  <= shreg_r[DQ_WIDTH-1:0];
                        shreg_r   <= shreg_r >> DQ_WIDTH;
                        dq_oe_r   <= 1'b1;
                        dqs_out_r <= 1'b1;
                        beat_r    <= 4'd1;
                    end else begin
                        pre_cnt_r <= pre_cnt_r - 2'd1;
                    end
                end
                ST_DATA: begin
                    if (beat_r == bl_r) begin
                        state_r   <= ST_IDLE;
                        dq_out_r  <= {DQ_WIDTH{1'b0}};
                        dq_oe_r   <= 1'b0;
                        dqs_oe_r  <= 1'b0;
                        dqs_out_r <= 1'b0;
                    end else begin
                        dq_out_r  <= shreg_r[DQ_WIDTH-1:0];
                        shreg_r   <= shreg_r >> DQ_WIDTH;
                        dqs_out_r <= ~beat_r[0];
                        beat_r    <= beat_r + 4'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    dq_out_r  <= {DQ_WIDTH{1'b0}};
                    dq_oe_r   <= 1'b0;
                    dqs_oe_r  <= 1'b0;
                    dqs_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid = cmd_valid_r;
    assign cmd_code  = cmd_code_r;
    assign cmd_addr  = cmd_addr_r;
    assign dq_out    = dq_out_r;
    assign dq_oe     = dq_oe_r;
    assign dqs_oe    = dqs_oe_r;
    assign dqs_out   = dqs_out_r;
    assign dimm_rd   = dimm_rd_r;
    assign err       = err_r;
endmodule

// File: tb/tb_burst_data_pipe.sv
module tb_burst_data_pipe;
    logic        clock_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [1:0]  req_rw = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        act_rdy = 1'b0, cas_rdy = 1'b0, rw_rdy = 1'b0, bc4 = 1'b0, wpre2 = 1'b0;
    logic        cmd_valid;
    logic [1:0]  cmd_code;
    logic [28:0] cmd_addr;
    logic [7:0]  dq_out;
    logic        dq_oe, dqs_oe, dqs_out, dimm_rd;
    logic [3:0]  pend_level, cas_level, rw_level;
    logic [2:0]  err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    localparam logic [1:0]  RD = 2'b01;
    localparam logic [1:0]  WR = 2'b10;
    localparam logic [63:0] W1 = 64'h0807060504030201;
    localparam logic [63:0] W2 = 64'h1122334455667788;

    burst_data_pipe dut (
        .clock_t(clock_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .act_rdy(act_rdy),
        .cas_rdy(cas_rdy), .rw_rdy(rw_rdy), .bc4(bc4), .wpre2(wpre2), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .cmd_addr(cmd_addr), .dq_out(dq_out), .dq_oe(dq_oe),
        .dqs_oe(dqs_oe), .dqs_out(dqs_out), .dimm_rd(dimm_rd), .pend_level(pend_level),
        .cas_level(cas_level), .rw_level(rw_level), .err(err)
    );

    always #5 clock_t = ~clock_t;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_t);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        @(negedge clock_t);
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [1:0] rw, input logic [31:0] a, input logic [63:0] d);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic check_cmd(input string tag, input logic v, input logic [1:0] c, input logic [28:0] a);
        check_val({tag, ".valid"}, 64'(cmd_valid), 64'(v));
        check_val({tag, ".code"},  64'(cmd_code),  64'(c));
        check_val({tag, ".addr"},  64'(cmd_addr),  64'(a));
    endtask

    task automatic check_drv(input string tag, input logic oe, input logic s_oe, input logic s, input logic [7:0] d);
        check_val({tag, ".dq_oe"},   64'(dq_oe),   64'(oe));
        check_val({tag, ".dqs_oe"},  64'(dqs_oe),  64'(s_oe));
        check_val({tag, ".dqs_out"}, 64'(dqs_out), 64'(s));
        check_val({tag, ".dq_out"},  64'(dq_out),  64'(d));
    endtask

    task automatic check_lvls(input string tag, input int p, input int c, input int r);
        check_val({tag, ".pend"}, 64'(pend_level), 64'(p));
        check_val({tag, ".cas"},  64'(cas_level),  64'(c));
        check_val({tag, ".rw"},   64'(rw_level),   64'(r));
    endtask

    // Check nbeats data beats from word w, then the return to idle drives.
    task automatic check_burst(input string tag, input logic [63:0] w, input int nbeats);
        logic [63:0] sh;
        sh = w;
        for (int k = 0; k < nbeats; k++) begin
            step();
            check_drv($sformatf("%s.beat%0d", tag, k), 1'b1, 1'b1, (k % 2 == 0), sh[7:0]);
            sh = sh >> 8;
        end
        step();
        check_drv({tag, ".end"}, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // Reset state
        #1;
        check_cmd("rst", 1'b0, 2'd0, 29'h0);
        check_drv("rst", 1'b0, 1'b0, 1'b0, 8'h00);
        check_lvls("rst", 0, 0, 0);
        check_val("rst.err", 64'(err), 64'h0);
        check_val("rst.dimm_rd", 64'(dimm_rd), 64'h0);
        check_val("rst.ready", 64'(req_ready), 64'h1);
        @(negedge clock_t);
        reset_n = 1'b1;

        // Write request: ACT then CAS_W, then 8-beat burst with 2-cycle preamble
        push(WR, 32'h0000_0100, W1);
        check_lvls("t1.push", 1, 0, 0);
        act_rdy = 1'b1; step(); act_rdy = 1'b0;
        check_cmd("t1.act", 1'b1, 2'd1, 29'h20);
        check_lvls("t1.act", 0, 1, 1);
        step();
        check_cmd("t1.gap", 1'b0, 2'd0, 29'h0);
        step(); step();
        cas_rdy = 1'b1; step(); cas_rdy = 1'b0;
        check_cmd("t1.cas", 1'b1, 2'd3, 29'h20);
        wpre2 = 1'b1; bc4 = 1'b0;
        rw_rdy = 1'b1; step(); rw_rdy = 1'b0;
        check_drv("t1.pre0", 1'b0, 1'b1, 1'b0, 8'h00);
        check_lvls("t1.popped", 0, 0, 0);
        step();
        check_drv("t1.pre1", 1'b0, 1'b1, 1'b0, 8'h00);
        check_burst("t1", W1, 8);
        check_val("t1.err", 64'(err), 64'h0);

        // Same data as BC4 with a 1-cycle preamble
        push(WR, 32'h0000_0100, W1);
        act_rdy = 1'b1; step(); act_rdy = 1'b0;
        wpre2 = 1'b0; bc4 = 1'b1;
        rw_rdy = 1'b1; step(); rw_rdy = 1'b0;
        check_drv("t2.pre0", 1'b0, 1'b1, 1'b0, 8'h00);
        check_burst("t2", W1, 4);

        // Fill the pending FIFO, hold the 9th request until an ACT frees space
        do_reset();
        req_valid = 1'b1; req_rw = RD; req_wdata = 64'h0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 32'(i * 8);
            check_val($sformatf("t3.ready%0d", i), 64'(req_ready), 64'h1);
            step();
        end
        check_val("t3.full.pend", 64'(pend_level), 64'd8);
        check_val("t3.full.ready", 64'(req_ready), 64'h0);
        req_addr = 32'h0000_1000;
        step();
        check_val("t3.held.pend", 64'(pend_level), 64'd8);
        act_rdy = 1'b1; step(); act_rdy = 1'b0;
        check_cmd("t3.act", 1'b1, 2'd1, 29'h0);
        check_lvls("t3.act", 7, 1, 1);
        check_val("t3.ready_again", 64'(req_ready), 64'h1);
        step();
        req_valid = 1'b0;
        check_val("t3.accepted.pend", 64'(pend_level), 64'd8);
        check_val("t3.accepted.ready", 64'(req_ready), 64'h0);

        // ACT coinciding with CAS: CAS first, ACT the following cycle
        do_reset();
        push(WR, 32'h0000_0040, W2);
        push(RD, 32'h0000_0080, 64'h0);
        act_rdy = 1'b1; step(); act_rdy = 1'b0;
        check_cmd("t4.act1", 1'b1, 2'd1, 29'h8);
        act_rdy = 1'b1; cas_rdy = 1'b1; step(); act_rdy = 1'b0; cas_rdy = 1'b0;
        check_cmd("t4.cas", 1'b1, 2'd3, 29'h8);
        check_lvls("t4.cas", 1, 0, 1);
        step();
        check_cmd("t4.act2", 1'b1, 2'd1, 29'h10);
        check_lvls("t4.act2", 0, 1, 2);
        step();
        check_cmd("t4.idle", 1'b0, 2'd0, 29'h0);
        check_val("t4.err", 64'(err), 64'h0);

        // CAS on empty and rw_rdy mid-burst set err[1] and err[2]
        cas_rdy = 1'b1; step();
        check_cmd("t5.casr", 1'b1, 2'd2, 29'h10);
        step(); cas_rdy = 1'b0;
        check_cmd("t5.cas_empty", 1'b0, 2'd0, 29'h0);
        check_val("t5.err1", 64'(err), 64'h2);
        wpre2 = 1'b0; bc4 = 1'b0;
        rw_rdy = 1'b1; step(); rw_rdy = 1'b0;
        check_drv("t5.pre0", 1'b0, 1'b1, 1'b0, 8'h00);
        step();
        check_drv("t5.beat0", 1'b1, 1'b1, 1'b1, 8'h88);
        rw_rdy = 1'b1; step(); rw_rdy = 1'b0;
        check_drv("t5.beat1", 1'b1, 1'b1, 1'b0, 8'h77);
        check_val("t5.err12", 64'(err), 64'h6);
        check_burst("t5.rest", W2 >> 16, 6);
        check_val("t5.rw_level", 64'(rw_level), 64'd1);

        // Asynchronous reset during beat 3, then a READ data phase
        do_reset();
        push(WR, 32'h0000_0200, W1);
        act_rdy = 1'b1; step(); act_rdy = 1'b0;
        rw_rdy = 1'b1; step(); rw_rdy = 1'b0;
        step(); step(); step(); step();
        check_drv("t6.beat3", 1'b1, 1'b1, 1'b0, 8'h04);
        #2;
        reset_n = 1'b0;
        #1;
        check_drv("t6.async", 1'b0, 1'b0, 1'b0, 8'h00);
        check_lvls("t6.async", 0, 0, 0);
        check_cmd("t6.async", 1'b0, 2'd0, 29'h0);
        @(negedge clock_t);
        reset_n = 1'b1;
        push(RD, 32'h0000_0300, 64'h0);
        act_rdy = 1'b1; step(); act_rdy = 1'b0;
        rw_rdy = 1'b1; step(); rw_rdy = 1'b0;
        check_val("t6.dimm_rd", 64'(dimm_rd), 64'h1);
        check_drv("t6.rd_nodrive", 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        check_val("t6.dimm_rd_end", 64'(dimm_rd), 64'h0);
        check_val("t6.err", 64'(err), 64'h0);

        // ACT on empty pending sets err[0] and issues nothing
        act_rdy = 1'b1; step(); act_rdy = 1'b0;
        check_cmd("t7.act_empty", 1'b0, 2'd0, 29'h0);
        check_val("t7.err0", 64'(err), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/burst_data_pipe.md
Name: burst_data_pipe

Overview:
Parametrised request pipeline between the sim-model traffic source and the DDR4 pin-level command/data buses. Host requests are buffered in a pending FIFO. Each controller ACT strobe moves the head request into separate CAS and RW FIFOs. CAS strobes issue column commands, and RW strobes launch a write-data burst FSM (preamble plus BL8/BC4 beats) or a read indication. Compared with the single-queue generation, it adds bounded depth, full/empty backpressure, command-bus arbitration, configurable beat width, and sticky error reporting.

Parameters:
ADDR_WIDTH, 32, host physical address width
TA_WIDTH, 29, mapped memory address width
ADDR_LSB, 3, low physical-address bits dropped by mapping (mem_addr[i] = addr[i+ADDR_LSB])
DQ_WIDTH, 8, data beat width
DEPTH, 8, entries per FIFO (power of two, >=2)

Ports:
clock_t  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  pending FIFO not full
req_rw  in  2  01=READ, 10=WRITE, others=NOP
req_addr  in  ADDR_WIDTH  physical address
req_wdata  in  8*DQ_WIDTH  write burst data, beat 0 in LSBs
act_rdy  in  1  controller: issue ACT now
cas_rdy  in  1  controller: issue CAS now
rw_rdy  in  1  controller: start data phase now
bc4  in  1  1=4-beat burst, 0=8-beat burst (sampled at burst start)
wpre2  in  1  1=2-cycle write preamble, 0=1-cycle
cmd_valid  out  1  command bus carries ACT/CAS
cmd_code  out  2  0=NOP 1=ACT 2=CAS_R 3=CAS_W
cmd_addr  out  TA_WIDTH  mapped address of issued command
dq_out  out  DQ_WIDTH  write data beat
dq_oe  out  1  dq_out valid
dqs_oe  out  1  strobe driven (preamble + data)
dqs_out  out  1  strobe level
dimm_rd  out  1  one-cycle pulse when a READ data phase starts
pend_level, cas_level, rw_level  out  $clog2(DEPTH)+1 each  FIFO occupancy
err  out  3  sticky: [0] ACT on empty pending or full CAS/RW FIFO, [1] CAS on empty, [2] RW on empty or while busy

Behaviour:
- Reset: all FIFOs empty, all levels 0, cmd_valid=0, cmd_code=0, cmd_addr=0, dq_out=0, dq_oe=0, dqs_oe=0, dqs_out=0, dimm_rd=0, err=0, FSM in IDLE, act_pend=0. An asserted reset mid-burst aborts immediately; queued entries are lost.
- Push: when req_valid && req_ready, store {rw, mapped addr, wdata}. req_ready = pend_level < DEPTH. This is combinational from registered state only.
- ACT path: when act_rdy or act_pend, pending is non-empty, and CAS and RW both have space:
  - pop pending; push {rw, addr} to CAS and {rw, wdata} to RW in the same cycle;
  - next cycle: cmd_valid=1, cmd_code=1, cmd_addr=addr.
  - If the condition fails on act_rdy: no pop, err[0] set, nothing issued.
- CAS path: when cas_rdy and CAS non-empty, pop. Next cycle cmd_code = 2 (READ), 3 (WRITE), or 0 with cmd_valid=0 (NOP rw). cas_rdy on empty: err[1].
- Arbitration: CAS wins the command bus. An act_rdy coinciding with cas_rdy sets act_pend, and ACT retries on the first later cycle without cas_rdy. act_pend clears when the ACT issues or fails with err[0]. Command outputs are NOP in every cycle with no issue.
- Simultaneous push and pop on the same FIFO is legal at any level, including full and empty-with-bypass-disallowed: a pushed entry is poppable no earlier than the next cycle. Read/write pointers wrap modulo DEPTH.
- Data FSM: IDLE -> PRE -> DATA -> IDLE.
  - rw_rdy in IDLE with RW non-empty pops an entry. WRITE: go to PRE with preamble count = wpre2?2:1 and latched bl = bc4?4:8. READ: dimm_rd=1 for the next cycle and stay IDLE. NOP: discarded.
  - PRE: dqs_oe=1, dqs_out=0, dq_oe=0 for the preamble count in cycles, then go to DATA.
  - DATA: one beat per cycle. dq_out = wdata[k*DQ_WIDTH +: DQ_WIDTH] for k=0..bl-1, dq_oe=1, dqs_oe=1, dqs_out=~k[0]. After beat bl-1, go to IDLE with all drives 0.
  - rw_rdy in PRE/DATA, or on empty RW: ignored, err[2] set.
- Latency: push-to-ACT-eligible 1 cycle. Strobe-to-command 1 cycle. rw_rdy to first DQS preamble 1 cycle; first data beat appears 1+preamble cycles after rw_rdy.

Test Plan:
- Write request addr 0x0000_0100 pushed; act_rdy; cas_rdy 3 cycles later -> ACT with cmd_addr 0x20, then CAS_W with cmd_addr 0x20, each one cycle after its strobe; levels return to 0.
- WRITE, wdata 0x0807060504030201, bc4=0, wpre2=1; rw_rdy -> 2 cycles dqs_oe=1/dq_oe=0, then dq_out 01,02,...,08 on 8 consecutive cycles with dqs_out 1,0,1,0..., then all drives 0; same with bc4=1 -> only 01..04.
- Push DEPTH+1 requests with no act_rdy -> req_ready drops after 8 accepts; 9th held until one act_rdy, then accepted.
- act_rdy and cas_rdy in the same cycle with one entry in CAS and one in pending -> CAS issues first, ACT the next cycle, err stays 0.
- cas_rdy on empty CAS, and rw_rdy during a DATA beat -> err=3'b110; burst completes unchanged.
- reset_n low during beat 3 -> all outputs 0 asynchronously, levels 0; after release, a new READ + rw_rdy gives a single dimm_rd pulse.
